// File: rtl/cp0_ctrl_if.sv
// Bus bundle between the M stage and the CP0 block: MTC0/MFC0 access,
// exception/ERET commit inputs and the status/cause/EPC/timer feedback.
interface cp0_ctrl_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] wdata_i;
  logic [5:0]  int_i;
  logic [4:0]  exception_code_i;
  logic        eret_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] badvaddr_i;
  logic [31:0] rdata_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;

  modport slave (
    input  we_i, waddr_i, raddr_i, wdata_i, int_i, exception_code_i,
           eret_i, pc_i, in_delayslot_i, badvaddr_i,
    output rdata_o, status_o, cause_o, epc_o, timer_int_o
  );

  modport master (
    output we_i, waddr_i, raddr_i, wdata_i, int_i, exception_code_i,
           eret_i, pc_i, in_delayslot_i, badvaddr_i,
    input  rdata_o, status_o, cause_o, epc_o, timer_int_o
  );
endinterface

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 register file: BadVAddr/Count/Compare/Status/Cause/EPC,
// exception entry, ERET and the Count/Compare timer interrupt.
module cp0_ctrl #(
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic          clk,
  input  logic          resetn,
  cp0_ctrl_if.slave     bus_if
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q,    count_d;
  logic        tick_q,     tick_d;
  logic [31:0] compare_q,  compare_d;
  logic [31:0] status_q,   status_d;
  logic [31:0] epc_q,      epc_d;
  logic        bd_q,       bd_d;
  logic [5:0]  ip_hw_q,    ip_hw_d;
  logic [1:0]  ip_sw_q,    ip_sw_d;
  logic [4:0]  exccode_q,  exccode_d;
  logic        timer_q,    timer_d;

  logic        exc_take;
  logic        eret_take;
  logic        mtc0_take;
  logic        timer_hit;
  logic [31:0] cause_val;

  // Priority resolution: an exception beats ERET, and either one kills the MTC0.
  always_comb begin
    exc_take  = ~bus_if.exception_code_i[4];
    eret_take = bus_if.eret_i & ~exc_take;
    mtc0_take = bus_if.we_i & ~exc_take & ~bus_if.eret_i;
    timer_hit = (compare_q != 32'd0) && (count_q == compare_q);
  end

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    tick_d     = ~tick_q;
    compare_d  = compare_q;
    status_d   = status_q;
    epc_d      = epc_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    timer_d    = timer_q | timer_hit;

    if (tick_q) begin
      count_d = count_q + 32'd1;
    end

    if (exc_take) begin
      exccode_d    = bus_if.exception_code_i;
      status_d[1]  = 1'b1;
      if (!status_q[1]) begin
        epc_d = bus_if.in_delayslot_i ? (bus_if.pc_i - 32'd4) : bus_if.pc_i;
        bd_d  = bus_if.in_delayslot_i;
      end
      if (bus_if.exception_code_i == 5'h04 || bus_if.exception_code_i == 5'h05) begin
        badvaddr_d = bus_if.badvaddr_i;
      end
    end else if (eret_take) begin
      status_d[1] = 1'b0;
    end else if (mtc0_take) begin
      case (bus_if.waddr_i)
        REG_COUNT: begin
          count_d = bus_if.wdata_i;
          tick_d  = 1'b0;
        end
        REG_COMPARE: begin
          compare_d = bus_if.wdata_i;
          timer_d   = 1'b0;
        end
        REG_STATUS: begin
          status_d = (status_q & ~STATUS_WMASK) | (bus_if.wdata_i & STATUS_WMASK);
        end
        REG_CAUSE: begin
          ip_sw_d = bus_if.wdata_i[9:8];
        end
        REG_EPC: begin
          epc_d = bus_if.wdata_i;
        end
        default: begin
        end
      endcase
    end

    // IP7 is shared between int_i[5] and the timer, so it follows the new timer state.
    ip_hw_d = {bus_if.int_i[5] | timer_d, bus_if.int_i[4:0]};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      tick_q     <= 1'b0;
      compare_q  <= 32'd0;
      status_q   <= RESET_STATUS;
      epc_q      <= 32'd0;
      bd_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exccode_q  <= 5'd0;
      timer_q    <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    cause_val = {bd_q, timer_q, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};
  end

  always_comb begin
    bus_if.rdata_o = 32'd0;
    case (bus_if.raddr_i)
      REG_BADVADDR: bus_if.rdata_o = badvaddr_q;
      REG_COUNT:    bus_if.rdata_o = count_q;
      REG_COMPARE:  bus_if.rdata_o = compare_q;
      REG_STATUS:   bus_if.rdata_o = status_q;
      REG_CAUSE:    bus_if.rdata_o = cause_val;
      REG_EPC:      bus_if.rdata_o = epc_q;
      default:      bus_if.rdata_o = 32'd0;
    endcase
  end

  assign bus_if.status_o    = status_q;
  assign bus_if.cause_o     = cause_val;
  assign bus_if.epc_o       = epc_q;
  assign bus_if.timer_int_o = timer_q;

endmodule
